// File: rtl/exec_unit.sv
// RV32I integer execute stage: single-cycle add/logic/compare, iterative 1-bit-per-cycle shifter,
// registered write-back packet with valid/ready handshakes on both sides.
module exec_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_fn,
  input  logic [1:0]      b_sel,
  input  logic            we_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu, OpIll
  } op_e;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   sh_q, sh_d;
  op_e               kind_q, kind_d;
  logic              pend_we_q, pend_we_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic              out_valid_q, out_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  op_e               op;
  logic [XLEN-1:0]   b_val;
  logic [CNT_W-1:0]  shamt;
  logic              bad;
  logic              is_shift;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   sh_next;
  logic              accept;
  logic              start_shift;

  always_comb begin
    op = OpIll;
    case (alu_fn)
      5'b00000, 5'b01010: op = OpAdd;
      5'b00001:           op = OpSub;
      5'b00010, 5'b01111: op = OpAnd;
      5'b00011, 5'b01110: op = OpOr;
      5'b00100, 5'b01101: op = OpXor;
      5'b00101, 5'b10000: op = OpSll;
      5'b00110, 5'b10011: op = OpSrl;
      5'b00111, 5'b10010: op = OpSra;
      5'b01000, 5'b01011: op = OpSlt;
      5'b01001, 5'b01100: op = OpSltu;
      default:            op = OpIll;
    endcase
  end

  always_comb begin
    b_val = '0;
    case (b_sel)
      2'b00:   b_val = rs2_val;
      2'b01:   b_val = imm;
      2'b10:   b_val = {{(XLEN-CNT_W){1'b0}}, imm[CNT_W-1:0]};
      default: b_val = '0;
    endcase
  end

  assign shamt    = b_val[CNT_W-1:0];
  assign bad      = (op == OpIll) || (b_sel == 2'b11);
  assign is_shift = !bad && (op == OpSll || op == OpSrl || op == OpSra);

  // Shift ops only reach this path with shamt == 0, so they pass operand A through.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:  alu_res = rs1_val + b_val;
      OpSub:  alu_res = rs1_val - b_val;
      OpAnd:  alu_res = rs1_val & b_val;
      OpOr:   alu_res = rs1_val | b_val;
      OpXor:  alu_res = rs1_val ^ b_val;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(b_val)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, rs1_val < b_val};
      OpSll, OpSrl, OpSra: alu_res = rs1_val;
      default: alu_res = '0;
    endcase
    if (bad) alu_res = '0;
  end

  always_comb begin
    sh_next = sh_q >> 1;
    case (kind_q)
      OpSll:   sh_next = sh_q << 1;
      OpSra:   sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      default: sh_next = sh_q >> 1;
    endcase
  end

  assign in_ready    = !reset && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift && (shamt != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    kind_d      = kind_q;
    pend_we_d   = pend_we_q;
    pend_rd_d   = pend_rd_q;
    out_valid_d = out_valid_q && !out_ready;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    illegal_d   = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (start_shift) begin
          state_d   = StShift;
          cnt_d     = shamt;
          sh_d      = rs1_val;
          kind_d    = op;
          pend_we_d = we_in && (rd_in != 5'd0);
          pend_rd_d = rd_in;
        end else if (accept) begin
          out_valid_d = 1'b1;
          wb_we_d     = we_in && (rd_in != 5'd0) && !bad;
          wb_rd_d     = rd_in;
          wb_data_d   = alu_res;
          illegal_d   = bad;
        end
      end
      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - CNT_W'(1);
        // Output register is guaranteed empty here: it drained on the accepting edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          wb_we_d     = pend_we_q;
          wb_rd_d     = pend_rd_q;
          wb_data_d   = sh_next;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      kind_q      <= OpAdd;
      pend_we_q   <= 1'b0;
      pend_rd_q   <= '0;
      out_valid_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      kind_q      <= kind_d;
      pend_we_q   <= pend_we_d;
      pend_rd_q   <= pend_rd_d;
      out_valid_q <= out_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: vector table plus scoreboard of expected write-back packets,
// with hand-written sequences for shift latency, back-to-back, backpressure and reset.
module tb_exec_unit;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } pkt_t;

  typedef struct {
    logic [4:0]  fn;
    logic [1:0]  bsel;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    pkt_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_fn;
  logic [1:0]  b_sel;
  logic        we_in;
  logic [4:0]  rd_in;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  pkt_t exp_q[$];
  int   pop_cyc[$];
  vec_t tbl[26];

  exec_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_fn    (alu_fn),
    .b_sel     (b_sel),
    .we_in     (we_in),
    .rd_in     (rd_in),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] fn, input logic [1:0] bs, input logic we,
                              input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im, input logic ewe, input logic [31:0] edata,
                              input logic eill);
    vec_t v;
    v.fn = fn; v.bsel = bs; v.we = we; v.rd = rd; v.a = a; v.b = b; v.im = im;
    v.exp.we = ewe; v.exp.rd = rd; v.exp.data = edata; v.exp.ill = eill;
    return v;
  endfunction

  // Scoreboard: every drained packet must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected packet", 32'(out_valid), 32'd0);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        check("wb_data", wb_data, e.data);
        check("wb_we", 32'(wb_we), 32'(e.we));
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  task automatic send(input vec_t v, input bit push);
    bit ok;
    ok = 1'b0;
    alu_fn = v.fn; b_sel = v.bsel; we_in = v.we; rd_in = v.rd;
    rs1_val = v.a; rs2_val = v.b; imm = v.im;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok && push) exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Measures cycles from the accepting edge to out_valid; in_ready must stay low meanwhile.
  task automatic send_timed(input string name, input vec_t v, input int lat);
    int k;
    int busy_bad;
    k = 0;
    busy_bad = 0;
    drain();
    send(v, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (in_ready) busy_bad++;
    end
    check({name, " latency"}, 32'(k), 32'(lat));
    check({name, " in_ready busy"}, 32'(busy_bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ov_seen;
    tbl[0]  = mk(5'b00000, 2'b00, 1, 5'd5,  32'h7FFFFFFF, 32'h1, 0, 1, 32'h80000000, 0);
    tbl[1]  = mk(5'b00001, 2'b00, 1, 5'd6,  32'h0, 32'h1, 0, 1, 32'hFFFFFFFF, 0);
    tbl[2]  = mk(5'b01000, 2'b00, 1, 5'd7,  32'hFFFFFFFF, 32'h1, 0, 1, 32'h1, 0);
    tbl[3]  = mk(5'b01001, 2'b00, 1, 5'd8,  32'hFFFFFFFF, 32'h1, 0, 1, 32'h0, 0);
    tbl[4]  = mk(5'b01100, 2'b01, 1, 5'd9,  32'h5, 32'h0, 32'hFFFFFFFF, 1, 32'h1, 0);
    tbl[5]  = mk(5'b00010, 2'b00, 1, 5'd10, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 1, 32'h00F000F0, 0);
    tbl[6]  = mk(5'b00011, 2'b00, 1, 5'd11, 32'h12340000, 32'h00005678, 0, 1, 32'h12345678, 0);
    tbl[7]  = mk(5'b00100, 2'b00, 1, 5'd12, 32'hFFFF0000, 32'h0F0F0F0F, 0, 1, 32'hF0F00F0F, 0);
    tbl[8]  = mk(5'b01010, 2'b01, 1, 5'd13, 32'hA, 32'h1234, 32'hFFFFFFFF, 1, 32'h9, 0);
    tbl[9]  = mk(5'b01011, 2'b01, 1, 5'd14, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 1, 32'h1, 0);
    tbl[10] = mk(5'b01101, 2'b01, 1, 5'd15, 32'hAAAAAAAA, 32'h0, 32'hFFFFFFFF, 1, 32'h55555555, 0);
    tbl[11] = mk(5'b01110, 2'b01, 1, 5'd16, 32'h0, 32'h0, 32'h80, 1, 32'h80, 0);
    tbl[12] = mk(5'b01111, 2'b01, 1, 5'd17, 32'hFFFF, 32'h0, 32'hF0, 1, 32'hF0, 0);
    tbl[13] = mk(5'b00000, 2'b00, 1, 5'd0,  32'h3, 32'h4, 0, 0, 32'h7, 0);
    tbl[14] = mk(5'b10001, 2'b00, 1, 5'd18, 32'h1, 32'h2, 0, 0, 32'h0, 1);
    tbl[15] = mk(5'b00000, 2'b11, 1, 5'd19, 32'h1, 32'h2, 32'h3, 0, 32'h0, 1);
    tbl[16] = mk(5'b00101, 2'b00, 1, 5'd20, 32'hDEADBEEF, 32'h20, 0, 1, 32'hDEADBEEF, 0);
    tbl[17] = mk(5'b00000, 2'b00, 0, 5'd3,  32'h1, 32'h1, 0, 0, 32'h2, 0);
    tbl[18] = mk(5'b01001, 2'b00, 1, 5'd21, 32'h1, 32'hFFFFFFFF, 0, 1, 32'h1, 0);
    tbl[19] = mk(5'b00101, 2'b00, 1, 5'd22, 32'h1, 32'h4, 0, 1, 32'h10, 0);
    tbl[20] = mk(5'b00110, 2'b00, 1, 5'd23, 32'h80000000, 32'h104, 0, 1, 32'h08000000, 0);
    tbl[21] = mk(5'b00111, 2'b00, 1, 5'd24, 32'h80000000, 32'h1, 0, 1, 32'hC0000000, 0);
    tbl[22] = mk(5'b10000, 2'b10, 1, 5'd25, 32'h3, 32'h0, 32'hFFFFFFE1, 1, 32'h6, 0);
    tbl[23] = mk(5'b01000, 2'b00, 1, 5'd26, 32'h5, 32'h5, 0, 1, 32'h0, 0);
    tbl[24] = mk(5'b00001, 2'b00, 1, 5'd27, 32'hA, 32'h3, 0, 1, 32'h7, 0);
    tbl[25] = mk(5'b10010, 2'b01, 1, 5'd28, 32'hF0000000, 32'h0, 32'hFE2, 1, 32'hFC000000, 0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_fn = '0; b_sel = '0; we_in = 1'b0; rd_in = '0; rs1_val = '0; rs2_val = '0; imm = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset wb_we", 32'(wb_we), 32'd0);
    check("reset wb_rd", 32'(wb_rd), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table-driven vectors, issued back to back
    for (int i = 0; i < 26; i++) send(tbl[i], 1'b1);
    drain();

    // Shift latency
    send_timed("srai31", mk(5'b10010, 2'b10, 1, 5'd1, 32'h80000000, 0, 32'h1F, 1, 32'hFFFFFFFF, 0),
               32);
    send_timed("srli31", mk(5'b10011, 2'b10, 1, 5'd2, 32'h80000000, 0, 32'h1F, 1, 32'h1, 0), 32);
    send_timed("sll n0", mk(5'b00101, 2'b00, 1, 5'd3, 32'h12345678, 32'h20, 0, 1, 32'h12345678, 0),
               1);
    send_timed("slli3", mk(5'b10000, 2'b10, 1, 5'd4, 32'h1, 0, 32'h3, 1, 32'h8, 0), 4);
    send_timed("add", mk(5'b00000, 2'b00, 1, 5'd5, 32'h1, 32'h2, 0, 1, 32'h3, 0), 1);
    drain();

    // Back-to-back addi: four packets on four consecutive cycles
    pop_cyc.delete();
    for (int i = 0; i < 4; i++)
      send(mk(5'b01010, 2'b01, 1, 5'(i + 1), 32'(100 + i), 0, 32'(i), 1, 32'(100 + 2 * i), 0),
           1'b1);
    drain();
    check("b2b packet count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) check("b2b span", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);

    // Backpressure: packet held stable, in_ready low, then resumes
    out_ready = 1'b0;
    send(mk(5'b00000, 2'b00, 1, 5'd9, 32'h100, 32'h23, 0, 1, 32'h123, 0), 1'b1);
    fork
      send(mk(5'b00001, 2'b00, 1, 5'd10, 32'h50, 32'h8, 0, 1, 32'h48, 0), 1'b1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall out_valid", 32'(out_valid), 32'd1);
          check("stall wb_data", wb_data, 32'h123);
          check("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a 20-bit sll abandons it
    send(mk(5'b00101, 2'b00, 1, 5'd11, 32'h1, 32'd20, 0, 1, 32'h100000, 0), 1'b0);
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check("mid-shift reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after reset in_ready", 32'(in_ready), 32'd1);
    check("after reset out_valid", 32'(out_valid), 32'd0);
    ov_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("stale packet cycles", 32'(ov_seen), 32'd0);
    @(posedge clk); #1;
    send(mk(5'b00000, 2'b00, 1, 5'd12, 32'h40, 32'h2, 0, 1, 32'h42, 0), 1'b1);
    drain();

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Consumer end of the decode-stage control interface.
- Accepts one decoded instruction bundle per handshake: alu_fn, B_SEL, we, rd, operand values and immediate.
- Executes the RV32I integer ALU operation and presents a registered write-back packet (we, rd, result) to the regfile write port.
- Add/logic/compare ops take 1 cycle. All shifts use an iterative 1-bit-per-cycle shifter, which gives a variable-latency valid/ready handshake on both sides.

Parameters:
XLEN, 32, datapath width
CNT_W, 5, shift counter width (log2 XLEN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  decoded bundle valid
in_ready  out  1  unit can accept a bundle this cycle
alu_fn  in  5  operation code from decode
b_sel  in  2  operand-B source: 00 rs2_val, 01 imm, 10 shamt = imm[4:0], 11 illegal
we_in  in  1  regfile write enable from decode
rd_in  in  5  destination register index
rs1_val  in  XLEN  operand A
rs2_val  in  XLEN  register operand B
imm  in  XLEN  sign-extended immediate
out_valid  out  1  write-back packet valid
out_ready  in  1  write-back consumer accepts packet
wb_we  out  1  write enable; forced 0 when rd==0
wb_rd  out  5  destination register
wb_data  out  XLEN  result
illegal  out  1  registered with packet; high for unlisted alu_fn or b_sel=11

Behaviour:
- Reset (synchronous, active-high, priority over all else):
  - out_valid=0, wb_we=0, wb_rd=0, wb_data=0, illegal=0.
  - State goes to IDLE; shift counter=0.
  - Reset mid-shift abandons the operation with no packet produced.
  - in_ready reads 0 in the reset cycle.
- Handshake rules:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept occurs on in_valid && in_ready.
  - The packet is held stable while out_valid && !out_ready.
  - Packet drains on out_valid && out_ready. If no new result is loaded on that same edge, out_valid returns to 0.
- Operand B = mux(b_sel). The shift amount is always B[4:0]; upper bits are ignored.
- alu_fn encoding (binary) -> op:
  - 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor
  - 00101 sll, 00110 srl, 00111 sra
  - 01000 slt, 01001 sltu
  - 01010 addi, 01011 slti, 01100 sltiu, 01101 xori, 01110 ori, 01111 andi
  - 10000 slli, 10011 srli, 10010 srai
  - Immediate forms compute identically to their register forms on the muxed B.
  - Any other code: wb_data=0, illegal=1, wb_we=0.
- Arithmetic rules:
  - Add/sub wrap modulo 2^XLEN.
  - slt/slti compare signed; sltu/sltiu compare unsigned.
  - Compare result is 1 or 0, zero-extended.
- Single-cycle ops (accept at edge T):
  - The result is loaded into the output register at edge T, so out_valid is high in cycle T+1.
  - Back-to-back accepts sustain 1 op/cycle while out_ready=1.
- Shift ops (sll/srl/sra/slli/srli/srai), shamt n:
  - n==0: behaves as a single-cycle op; result is rs1_val.
  - n>0: at accept, load shift register=rs1_val, count=n, latch op/rd/we, go to SHIFT.
  - In SHIFT, each edge shifts by 1 bit and decrements count:
    - sll fills 0; srl fills 0; sra fills the sign bit.
  - The edge where count goes 1->0 writes the output register and returns to IDLE.
  - out_valid rises in cycle T+n+1.
  - in_ready=0 throughout SHIFT. out_valid is guaranteed 0 during SHIFT, because the output register drained at accept.
- State machine:
  - IDLE -> SHIFT on accept of a shift with n>0.
  - SHIFT -> IDLE when count reaches 0.
  - No other states.
- wb_we = we_in && rd_in!=0 && !illegal, latched at accept.
- Inputs are ignored whenever in_ready=0.

Test Plan:
- Reset, then add rs1=0x7FFFFFFF rs2=1 rd=5 -> next cycle out_valid=1, wb_data=0x80000000, wb_we=1, wb_rd=5. Repeat with sub 0 - 1 -> 0xFFFFFFFF.
- slt rs1=0xFFFFFFFF, rs2=1 -> wb_data=1. sltu with the same operands -> 0. sltiu imm=0xFFFFFFFF, rs1=5 -> 1.
- srai b_sel=10 imm[4:0]=31, rs1=0x80000000, accept at T -> in_ready=0 for cycles T+1..T+31, out_valid at T+32, wb_data=0xFFFFFFFF. srli with the same operands -> 0x00000001. sll with rs2=0x20 (n=0) -> 1-cycle latency, wb_data=rs1.
- Back-to-back: 4 consecutive addi with out_ready=1 -> 4 packets in 4 consecutive cycles. Hold out_ready=0 for 3 cycles -> packet stable and in_ready=0, then resumes.
- rd=0 with add -> wb_we=0, wb_data still computed. alu_fn=10001 -> illegal=1, wb_data=0, wb_we=0.
- Assert reset at cycle T+5 of a 20-bit sll -> out_valid stays 0, in_ready=1 the cycle after reset deasserts, and no stale packet is ever emitted.
